// File: rtl/floor_request_manager.sv
// Latches hall/cabin requests for two cars and runs a per-car door dwell FSM on arrival.
// Optional FRM_DOOR_REOPEN_EN: a same-floor press while the door cycle runs reopens/extends it.
module floor_request_manager #(
   parameter int NUM_FLOORS   = 6,
   parameter int DWELL_CYCLES = 60,
   parameter int CLOSE_CYCLES = 4,
   parameter int CNT_W        = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2*NUM_FLOORS-1:0] call_btn,
   input  logic [2*NUM_FLOORS-1:0] dest_btn,
   input  logic [7:0]              elevatorPosition,
   output logic [2*NUM_FLOORS-1:0] FloorsRequested,
   output logic [2*NUM_FLOORS-1:0] FloorDestinations,
   output logic [1:0]              hold,
   output logic [1:0]              door_open,
   output logic [1:0]              arrived
);

   localparam int NW = 2 * NUM_FLOORS;
   localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLOSE_LD = CNT_W'(CLOSE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DOOR_OPEN, CLOSING} state_t;

   logic [NW-1:0] clr_all;
   logic [NW-1:0] block_all;

   // Car index 1 is the left car: request bits [NUM_FLOORS-1:0], position [7:4].
   for (genvar c = 0; c < 2; c++) begin : g_car
      localparam int BASE = (1 - c) * NUM_FLOORS;

      state_t                state_q, state_d;
      logic [CNT_W-1:0]      cnt_q, cnt_d;
      logic [3:0]            pos;
      logic [NUM_FLOORS-1:0] at_floor;
      logic [NUM_FLOORS-1:0] pend;
      logic [NUM_FLOORS-1:0] clr;
      logic [NUM_FLOORS-1:0] block;
      logic                  arrive;
`ifdef FRM_DOOR_REOPEN_EN
      logic [NUM_FLOORS-1:0] served_q, served_d;
      logic [NUM_FLOORS-1:0] press;
      assign press = call_btn[BASE +: NUM_FLOORS] | dest_btn[BASE +: NUM_FLOORS];
`endif

      assign pos  = elevatorPosition[4*c +: 4];
      assign pend = FloorsRequested[BASE +: NUM_FLOORS] | FloorDestinations[BASE +: NUM_FLOORS];

      // Odd codes and codes past the top floor match no floor.
      always_comb begin
         at_floor = '0;
         for (int f = 0; f < NUM_FLOORS; f++) begin
            at_floor[f] = (pos == 4'(2 * f));
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         clr     = '0;
         block   = '0;
         arrive  = 1'b0;
`ifdef FRM_DOOR_REOPEN_EN
         served_d = served_q;
`endif
         unique case (state_q)
            IDLE: begin
               if ((at_floor & pend) != '0) begin
                  state_d = DOOR_OPEN;
                  cnt_d   = DWELL_LD;
                  clr     = at_floor;
                  arrive  = 1'b1;
`ifdef FRM_DOOR_REOPEN_EN
                  served_d = at_floor;
`endif
               end
            end
            DOOR_OPEN: begin
               if (cnt_q == '0) begin
                  state_d = CLOSING;
                  cnt_d   = CLOSE_LD;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            CLOSING: begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
`ifdef FRM_DOOR_REOPEN_EN
         // A press for the floor being served restarts the dwell instead of latching.
         if (state_q != IDLE && (press & served_q) != '0) begin
            block   = served_q;
            state_d = DOOR_OPEN;
            cnt_d   = DWELL_LD;
         end
`endif
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            arrived[c] <= 1'b0;
`ifdef FRM_DOOR_REOPEN_EN
            served_q   <= '0;
`endif
         end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            arrived[c] <= arrive;
`ifdef FRM_DOOR_REOPEN_EN
            served_q   <= served_d;
`endif
         end
      end

      assign hold[c]      = (state_q != IDLE);
      assign door_open[c] = (state_q == DOOR_OPEN);
      assign clr_all[BASE +: NUM_FLOORS]   = clr;
      assign block_all[BASE +: NUM_FLOORS] = block;
   end

   // Clearing only touches the floor served this cycle, so any other set wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         FloorsRequested   <= '0;
         FloorDestinations <= '0;
      end else begin
         FloorsRequested   <= (FloorsRequested | (call_btn & ~block_all)) & ~clr_all;
         FloorDestinations <= (FloorDestinations | (dest_btn & ~block_all)) & ~clr_all;
      end
   end

endmodule
